// File: rtl/rng_bounded_sampler_if.sv
// Handshake bundle between a client, the upstream RNG and the
// bounded sampler: random word feed, request and result channels.
interface rng_bounded_sampler_if;
    logic [31:0] rnd_in;
    logic        rnd_valid;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_bound;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_biased;

    modport master (
        output rnd_in,
        output rnd_valid,
        output req_valid,
        output req_bound,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_biased
    );

    modport slave (
        input  rnd_in,
        input  rnd_valid,
        input  req_valid,
        input  req_bound,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_biased
    );
endinterface

// File: rtl/rng_bounded_sampler.sv
// Mask-and-reject sampler: turns raw 32-bit random words into a value
// uniform in [0, N), with a bounded retry count and a flagged fallback.
module rng_bounded_sampler #(
    parameter int unsigned MAX_TRIES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rng_bounded_sampler_if.slave bus,
    output logic [CNT_W-1:0]     reject_count
);

    typedef enum logic [1:0] {
        IDLE,
        MASK,
        DRAW,
        HOLD
    } state_t;

    localparam logic [15:0] TRY_LAST = 16'(MAX_TRIES);

    state_t state_q;
    state_t state_d;

    logic [31:0]      bound_q;
    logic [31:0]      mask_q;
    logic [15:0]      tries_q;
    logic [31:0]      out_data_q;
    logic             out_biased_q;
    logic [CNT_W-1:0] reject_q;

    logic [31:0] sample;
    logic [31:0] fallback;
    logic [31:0] mask_d;
    logic [15:0] tries_inc;
    logic        accept;
    logic        last_try;
    logic        rejected;
    logic        finish;

    logic latch_req;
    logic load_mask;
    logic fire;

    // Smallest 2^k-1 covering x: fold every set bit into all lower bits.
    function automatic logic [31:0] smear(input logic [31:0] x);
        logic [31:0] m;
        m = x;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

    assign mask_d = (bound_q == 32'd0) ? 32'hFFFF_FFFF
                                       : smear(bound_q - 32'd1);

    assign sample    = bus.rnd_in & mask_q;
    assign fallback  = sample - bound_q;
    assign tries_inc = tries_q + 16'd1;
    assign accept    = (bound_q == 32'd0) || (sample < bound_q);
    assign last_try  = (tries_inc == TRY_LAST);
    assign rejected  = fire && !accept;
    assign finish    = fire && (accept || last_try);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = MASK;
                end
            end
            MASK: begin
                state_d = DRAW;
            end
            DRAW: begin
                if (finish) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.out_valid = 1'b0;
        latch_req     = 1'b0;
        load_mask     = 1'b0;
        fire          = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                latch_req     = bus.req_valid;
            end
            MASK: begin
                load_mask = 1'b1;
            end
            DRAW: begin
                fire = bus.rnd_valid;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
            end
            default: begin
                fire = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bound_q      <= '0;
            mask_q       <= '0;
            tries_q      <= '0;
            out_data_q   <= '0;
            out_biased_q <= 1'b0;
        end else begin
            if (latch_req) begin
                bound_q <= bus.req_bound;
            end
            if (load_mask) begin
                mask_q  <= mask_d;
                tries_q <= '0;
            end
            if (fire) begin
                tries_q <= tries_inc;
            end
            if (fire && accept) begin
                out_data_q   <= sample;
                out_biased_q <= 1'b0;
            end else if (fire && last_try) begin
                // mask <= 2N-2, so sample-N always lands below N
                out_data_q   <= fallback;
                out_biased_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_q <= '0;
        end else if (rejected && (reject_q != {CNT_W{1'b1}})) begin
            reject_q <= reject_q + CNT_W'(1);
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_biased = out_biased_q;
    assign reject_count   = reject_q;

endmodule

// File: tb/tb_rng_bounded_sampler.sv
// Scoreboard bench for rng_bounded_sampler: a default instance and a
// MAX_TRIES=4 / 3-bit counter instance driven from one initial block.
module tb_rng_bounded_sampler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rng_bounded_sampler_if bus0 ();
    rng_bounded_sampler_if bus4 ();

    logic [15:0] cnt0;
    logic [2:0]  cnt4;

    rng_bounded_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0),
        .reject_count (cnt0)
    );

    rng_bounded_sampler #(
        .MAX_TRIES (4),
        .CNT_W     (3)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus4),
        .reject_count (cnt4)
    );

    typedef struct {
        logic [31:0] data;
        bit          biased;
        int          lat;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt0 = 0;
    int exp_cnt4 = 0;

    task automatic set_rnd(input logic [31:0] v, input bit ok);
        bus0.rnd_in    = v;
        bus0.rnd_valid = ok;
        bus4.rnd_in    = v;
        bus4.rnd_valid = ok;
    endtask

    task automatic drive_idle();
        bus0.req_valid = 1'b0;
        bus0.req_bound = '0;
        bus0.out_ready = 1'b0;
        bus4.req_valid = 1'b0;
        bus4.req_bound = '0;
        bus4.out_ready = 1'b0;
        set_rnd('0, 1'b1);
    endtask

    // Runs one request; rv/vv give rnd_in/rnd_valid per DRAW-phase cycle.
    task automatic run_txn(
        input  bit          sel4,
        input  logic [31:0] bound,
        input  logic [31:0] rv[16],
        input  bit          vv[16],
        input  int          hold_low,
        output logic [31:0] d,
        output bit          b,
        output int          lat,
        output int          cnt,
        output bit          stable_ok,
        output bit          idle_ok
    );
        int c;
        int idx;
        bit got;
        bit ov;
        d = '0;
        b = 1'b0;
        lat = -1;
        cnt = -1;
        stable_ok = 1'b0;
        idle_ok = 1'b0;
        got = 1'b0;
        c = 0;
        @(negedge clk);
        if (sel4) begin
            bus4.req_valid = 1'b1;
            bus4.req_bound = bound;
        end else begin
            bus0.req_valid = 1'b1;
            bus0.req_bound = bound;
        end
        set_rnd(rv[0], vv[0]);
        while (!got && c < 100) begin
            @(negedge clk);
            c++;
            bus0.req_valid = 1'b0;
            bus4.req_valid = 1'b0;
            idx = (c < 2) ? 0 : ((c - 2) > 15 ? 15 : c - 2);
            set_rnd(rv[idx], vv[idx]);
            ov = sel4 ? bus4.out_valid : bus0.out_valid;
            if (ov) begin
                got = 1'b1;
                lat = c;
                d = sel4 ? bus4.out_data : bus0.out_data;
                b = sel4 ? bus4.out_biased : bus0.out_biased;
                cnt = sel4 ? int'(cnt4) : int'(cnt0);
            end
        end
        if (got) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold_low; i++) begin
                @(negedge clk);
                if (sel4) begin
                    if (!bus4.out_valid || bus4.req_ready ||
                        bus4.out_data !== d ||
                        bus4.out_biased !== b)
                        stable_ok = 1'b0;
                end else begin
                    if (!bus0.out_valid || bus0.req_ready ||
                        bus0.out_data !== d ||
                        bus0.out_biased !== b)
                        stable_ok = 1'b0;
                end
            end
            bus0.out_ready = 1'b1;
            bus4.out_ready = 1'b1;
            if (sel4 ? bus4.req_ready : bus0.req_ready)
                stable_ok = 1'b0;
            @(negedge clk);
            bus0.out_ready = 1'b0;
            bus4.out_ready = 1'b0;
            if (sel4)
                idle_ok = bus4.req_ready && !bus4.out_valid;
            else
                idle_ok = bus0.req_ready && !bus0.out_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus0.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got %b want 0", bus0.out_valid);
        end
        n_cmp++;
        if (bus0.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_req_ready got %b want 1", bus0.req_ready);
        end
        n_cmp++;
        if (cnt0 !== 16'd0 || cnt4 !== 3'd0) begin
            n_err++;
            $display("FAIL rst_count got %0d/%0d want 0/0", cnt0, cnt4);
        end
        n_cmp++;
        if (bus0.out_data !== 32'd0 || bus0.out_biased !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out got %h/%b want 0/0",
                     bus0.out_data, bus0.out_biased);
        end
        // Park the default instance in DRAW with N=5 and rnd_in=7.
        bus0.req_valid = 1'b1;
        bus0.req_bound = 32'd5;
        set_rnd(32'd7, 1'b1);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (cnt0 !== 16'd3 || bus0.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pre_rst_draw got cnt %0d ov %b want 3 0",
                     cnt0, bus0.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus0.out_valid !== 1'b0 || cnt0 !== 16'd0) begin
            n_err++;
            $display("FAIL async_rst got ov %b cnt %0d want 0 0",
                     bus0.out_valid, cnt0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (bus0.req_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst got rr %b ov %b want 1 0",
                     bus0.req_ready, bus0.out_valid);
        end
        exp_cnt0 = 0;
        exp_cnt4 = 0;
    endtask

    task automatic check_txn(
        input string       name,
        input logic [31:0] d,
        input bit          b,
        input int          lat,
        input int          cnt
    );
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL %s_lat got %0d want %0d", name, lat, e.lat);
        end
        n_cmp++;
        if (d !== e.data || b !== e.biased) begin
            n_err++;
            $display("FAIL %s_data got %h/%b want %h/%b",
                     name, d, b, e.data, e.biased);
        end
        n_cmp++;
        if (cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s_cnt got %0d want %0d", name, cnt, e.cnt);
        end
    endtask

    task automatic fill(
        output logic [31:0] rv[16],
        output bit          vv[16],
        input  logic [31:0] v
    );
        for (int i = 0; i < 16; i++) begin
            rv[i] = v;
            vv[i] = 1'b1;
        end
    endtask

    task automatic push(
        input logic [31:0] d,
        input bit          b,
        input int          lat,
        input int          cnt
    );
        exp_t e;
        e.data = d;
        e.biased = b;
        e.lat = lat;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic test_bound_one();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'hFFFF_FFFF);
        push(32'd0, 1'b0, 3, exp_cnt0);
        run_txn(1'b0, 32'd1, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("bound_one", d, b, lat, cnt);
    endtask

    task automatic test_pow2();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'h1234_5675);
        push(32'd5, 1'b0, 3, exp_cnt0);
        run_txn(1'b0, 32'd8, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("pow2", d, b, lat, cnt);
    endtask

    task automatic test_reject();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'd3);
        rv[0] = 32'd7;
        rv[1] = 32'd6;
        exp_cnt0 += 2;
        push(32'd3, 1'b0, 5, exp_cnt0);
        run_txn(1'b0, 32'd5, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("reject", d, b, lat, cnt);
    endtask

    task automatic test_stall();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'd3);
        rv[0] = 32'd7;
        rv[1] = 32'd0;
        vv[1] = 1'b0;
        rv[2] = 32'd0;
        vv[2] = 1'b0;
        rv[3] = 32'd6;
        exp_cnt0 += 2;
        push(32'd3, 1'b0, 7, exp_cnt0);
        run_txn(1'b0, 32'd5, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("stall", d, b, lat, cnt);
    endtask

    task automatic test_fallback();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'hFFFF_FFFF);
        exp_cnt4 = (exp_cnt4 + 4 > 7) ? 7 : exp_cnt4 + 4;
        push(32'd2, 1'b1, 6, exp_cnt4);
        run_txn(1'b1, 32'd5, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("fallback4", d, b, lat, cnt);
        exp_cnt0 += 16;
        push(32'd2, 1'b1, 18, exp_cnt0);
        run_txn(1'b0, 32'd5, rv, vv, 1, d, b, lat, cnt, st, id);
        check_txn("fallback16", d, b, lat, cnt);
    endtask

    task automatic test_saturate();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'hFFFF_FFFF);
        exp_cnt4 = (exp_cnt4 + 4 > 7) ? 7 : exp_cnt4 + 4;
        push(32'd2, 1'b1, 6, exp_cnt4);
        run_txn(1'b1, 32'd5, rv, vv, 0, d, b, lat, cnt, st, id);
        check_txn("saturate", d, b, lat, cnt);
    endtask

    task automatic test_hold();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        bit b, st, id;
        int lat, cnt;
        fill(rv, vv, 32'hDEAD_BEEF);
        push(32'hDEAD_BEEF, 1'b0, 3, exp_cnt0);
        run_txn(1'b0, 32'd0, rv, vv, 10, d, b, lat, cnt, st, id);
        check_txn("hold", d, b, lat, cnt);
        n_cmp++;
        if (st !== 1'b1) begin
            n_err++;
            $display("FAIL hold_stable got %b want 1", st);
        end
        n_cmp++;
        if (id !== 1'b1) begin
            n_err++;
            $display("FAIL hold_idle got %b want 1", id);
        end
    endtask

    function automatic exp_t model(
        input int          mt,
        input logic [31:0] n,
        input logic [31:0] rv[16],
        input bit          vv[16]
    );
        exp_t e;
        logic [31:0] m;
        logic [31:0] mask;
        logic [31:0] s;
        int tries;
        int k;
        int idx;
        bit done;
        mask = 32'hFFFF_FFFF;
        if (n != 32'd0) begin
            m = n - 32'd1;
            mask = 32'd0;
            for (int i = 0; i < 32; i++)
                if (m >= (32'd1 << i))
                    mask[i] = 1'b1;
        end
        e.data = '0;
        e.biased = 1'b0;
        e.lat = -1;
        e.cnt = 0;
        tries = 0;
        k = 0;
        done = 1'b0;
        while (!done && k < 90) begin
            idx = (k > 15) ? 15 : k;
            if (vv[idx]) begin
                s = rv[idx] & mask;
                tries++;
                if (n == 32'd0 || s < n) begin
                    e.data = s;
                    done = 1'b1;
                end else begin
                    e.cnt++;
                    if (tries == mt) begin
                        e.data = s - n;
                        e.biased = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            if (done)
                e.lat = 3 + k;
            k++;
        end
        return e;
    endfunction

    task automatic test_back_to_back();
        logic [31:0] rv[16];
        bit vv[16];
        logic [31:0] d;
        logic [31:0] n;
        bit b, st, id, sel;
        int lat, cnt, hl;
        exp_t e;
        for (int t = 0; t < 40; t++) begin
            sel = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: n = 32'd0;
                1: n = 32'($urandom_range(1, 40));
                2: n = $urandom | 32'h8000_0001;
                default: n = 32'd1 << $urandom_range(0, 31);
            endcase
            for (int i = 0; i < 16; i++) begin
                rv[i] = $urandom;
                if (n != 32'd0 && n < 32'd64 && $urandom_range(0, 1) == 1)
                    rv[i] = rv[i] & 32'h3F;
                vv[i] = ($urandom_range(0, 3) != 0);
            end
            vv[15] = 1'b1;
            hl = $urandom_range(0, 2);
            e = model(sel ? 4 : 16, n, rv, vv);
            if (sel) begin
                exp_cnt4 = (exp_cnt4 + e.cnt > 7) ? 7 : exp_cnt4 + e.cnt;
                e.cnt = exp_cnt4;
            end else begin
                exp_cnt0 += e.cnt;
                e.cnt = exp_cnt0;
            end
            sb.push_back(e);
            run_txn(sel, n, rv, vv, hl, d, b, lat, cnt, st, id);
            check_txn("b2b", d, b, lat, cnt);
            n_cmp++;
            if (st !== 1'b1 || id !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_hs got %b%b want 11", st, id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bound_one();
        test_pow2();
        test_reject();
        test_stall();
        test_fallback();
        test_saturate();
        test_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rng_bounded_sampler.md
Name: rng_bounded_sampler

Overview:
- Downstream consumer of a free-running 32-bit uniform RNG stage; the xorshift/taus generators' rnd output connects to rnd_in.
- Converts raw 32-bit words into an integer uniformly distributed in [0, bound) using mask-and-reject sampling.
- Request and response use valid/ready handshakes, so it can serve an arbitrary client (e.g. a sampler front-end or test harness).
- A bounded retry limit guarantees forward progress; a fallback result is flagged as biased.

Parameters:
MAX_TRIES, 16, maximum draws per request before the fallback is taken; legal range 1..65535
CNT_W, 16, width of the saturating rejection statistics counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rnd_in  in  32  random word from the upstream generator; sampled only in DRAW
rnd_valid  in  1  rnd_in holds a fresh word this cycle; tie high for free-running generators
req_valid  in  1  a request is presented
req_ready  out  1  block can accept a request; high only in IDLE
req_bound  in  32  exclusive upper bound N; N=0 means full 2^32 range
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_data  out  32  sampled value
out_biased  out  1  out_data was produced by the fallback path
reject_count  out  CNT_W  total rejected draws since reset; saturates at all-ones

Behaviour:
- Reset (asynchronous, any state): state=IDLE; out_valid=0; out_data=0; out_biased=0; reject_count=0; internal bound, mask and try counter cleared. req_ready=1 once rst deasserts.
- FSM states: IDLE, MASK, DRAW, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid, latch N=req_bound and go to MASK.
- MASK (1 cycle):
  - mask = bitwise smear of (N-1), i.e. the smallest 2^k-1 that is >= N-1.
  - N=0 gives mask=0xFFFFFFFF; N=1 gives mask=0.
  - Clear the try counter, go to DRAW.
- DRAW:
  - If rnd_valid=0, stall in DRAW; no counters change.
  - If rnd_valid=1:
    - s = rnd_in & mask; increment the try counter.
    - Accept when N=0 or s < N: out_data=s, out_biased=0, go to HOLD.
    - Else, if the try count (after increment) equals MAX_TRIES: out_data = s - N, out_biased=1, go to HOLD. The result is always < N because mask <= 2N-2.
    - Else stay in DRAW.
    - Every rejected draw, including the fallback draw, increments reject_count (saturating).
- HOLD:
  - out_valid=1; out_data and out_biased stable.
  - On out_ready: out_valid drops next cycle, return to IDLE.
  - req_ready=0, so a new request is not accepted in the same cycle as the handshake.
- Latency: request handshake at cycle T.
  - First draw at T+2.
  - If the first draw accepts, out_valid rises at T+3.
  - Each rejection or rnd_valid stall adds 1 cycle.
  - Throughput is at most one result per 4 cycles.
- req_valid and req_bound are ignored outside IDLE. out_ready is ignored outside HOLD.
- Arithmetic is unsigned 32-bit throughout. N-1 is computed only for N != 0.

Test Plan:
- Reset mid-DRAW (N=5, rnd_in held at 7), assert rst asynchronously → out_valid=0, reject_count=0 immediately, req_ready=1 after release.
- N=1, rnd_in=0xFFFFFFFF, out_ready=1 → out_data=0x00000000 at T+3, out_biased=0, reject_count unchanged.
- N=8, rnd_in=0x12345675 → mask 7, out_data=5 at T+3, no rejection.
- N=5, rnd_in sequence 0x7, 0x6, 0x3 on draw cycles → out_data=3 at T+5, reject_count +2; with rnd_valid low for 2 cycles mid-sequence → result at T+7, count still +2.
- MAX_TRIES=4, N=5, rnd_in held at 0xFFFFFFFF → after 4 draws out_data=2, out_biased=1, reject_count +4.
- N=0, rnd_in=0xDEADBEEF with out_ready low for 10 cycles → out_data=0xDEADBEEF held stable with out_valid=1 and req_ready=0 throughout; IDLE the cycle after out_ready rises.
